// File: rtl/div_iter_core.sv
// -----------------------------------------------------------------------------
// div_iter_core
//   Iterative 32-bit integer divider that produces one quotient bit per clock.
//   It uses a restoring shift-subtract algorithm and supports signed (DIV) and
//   unsigned (DIVU) operation.
//
// Ports
//   clk           : clock; all state changes on the rising edge
//   rst           : asynchronous, active-high reset
//   signed_div_i  : 1 = signed divide, 0 = unsigned (sampled on acceptance)
//   opdata1_i     : dividend (sampled on acceptance)
//   opdata2_i     : divisor  (sampled on acceptance)
//   start_i       : divide request, held high until ready_o is seen
//   annul_i       : cancel a requested or in-flight divide
//   result_o      : {remainder, quotient}, registered
//   ready_o       : result valid, registered; high only in DONE
// -----------------------------------------------------------------------------
module div_iter_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BYZERO = 2'd1,
        ST_BUSY   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t      state_q;
    logic [64:0] work_q;      // {partial remainder[64:32], dividend/quotient[31:0]}
    logic [31:0] divisor_q;   // divisor magnitude
    logic [5:0]  cnt_q;       // steps completed
    logic        quot_neg_q;  // quotient must be negated at the end
    logic        rem_neg_q;   // remainder takes the dividend's (negative) sign
    logic [63:0] result_q;
    logic        ready_q;

    logic [33:0] trial_d;
    logic [64:0] work_d;
    logic [31:0] quot_d;
    logic [31:0] rem_d;

    // Two's-complement negate
    function automatic logic [31:0] negate32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    // Magnitude of an operand, negated only when signed mode sees a negative value
    function automatic logic [31:0] magnitude(input logic is_signed, input logic [31:0] v);
        return (is_signed && v[31]) ? negate32(v) : v;
    endfunction

    // One restoring step: shift left, trial-subtract divisor, keep or restore
    always_comb begin
        trial_d = {work_q[64:31]};
        work_d  = work_q;
        if (trial_d >= {2'b00, divisor_q}) begin
            work_d = {33'(trial_d - {2'b00, divisor_q}), work_q[30:0], 1'b1};
        end else begin
            work_d = {trial_d[32:0], work_q[30:0], 1'b0};
        end
        quot_d = quot_neg_q ? negate32(work_d[31:0])  : work_d[31:0];
        rem_d  = rem_neg_q  ? negate32(work_d[63:32]) : work_d[63:32];
    end

    // Divider control FSM with registered result and ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            work_q     <= 65'd0;
            divisor_q  <= 32'd0;
            cnt_q      <= 6'd0;
            quot_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
            result_q   <= 64'd0;
            ready_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ready_q <= 1'b0;
                    if (start_i && !annul_i) begin
                        work_q     <= {33'd0, magnitude(signed_div_i, opdata1_i)};
                        divisor_q  <= magnitude(signed_div_i, opdata2_i);
                        quot_neg_q <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
                        rem_neg_q  <= signed_div_i & opdata1_i[31];
                        cnt_q      <= 6'd0;
                        state_q    <= (opdata2_i == 32'd0) ? ST_BYZERO : ST_BUSY;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_BYZERO: begin
                    if (annul_i) begin
                        state_q <= ST_IDLE;
                    end else begin
                        result_q <= 64'd0;
                        ready_q  <= 1'b1;
                        state_q  <= ST_DONE;
                    end
                end
                ST_BUSY: begin
                    if (annul_i) begin
                        // Partial work is simply abandoned; result_q is untouched
                        cnt_q   <= 6'd0;
                        state_q <= ST_IDLE;
                    end else if (cnt_q == 6'd31) begin
                        work_q   <= work_d;
                        cnt_q    <= 6'd0;
                        result_q <= {rem_d, quot_d};
                        ready_q  <= 1'b1;
                        state_q  <= ST_DONE;
                    end else begin
                        work_q <= work_d;
                        cnt_q  <= cnt_q + 6'd1;
                    end
                end
                ST_DONE: begin
                    // A held start_i keeps the result presented; no implicit restart
                    if (annul_i || !start_i) begin
                        ready_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        ready_q <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    ready_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_iter_core.sv
// -----------------------------------------------------------------------------
// tb_div_iter_core
//   Self-checking bench for div_iter_core. Expected results come from a
//   behavioural model that uses native 64-bit arithmetic.
// -----------------------------------------------------------------------------
module tb_div_iter_core;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int errors;
    int checks;

    div_iter_core dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: truncating division on 64-bit integers, zero divisor gives 0
    function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint la, lb, q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            la = longint'($signed(a));
            lb = longint'($signed(b));
        end else begin
            la = longint'({32'd0, a});
            lb = longint'({32'd0, b});
        end
        q = la / lb;
        r = la % lb;
        return {r[31:0], q[31:0]};
    endfunction

    // Run one divide; mode 0 = drop start after done, mode 1 = annul in DONE
    task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                           input int mode, input string name);
        logic [63:0] exp_res;
        int          exp_lat;
        int          lat;
        exp_res = ref_div(s, a, b);
        exp_lat = (b == 32'd0) ? 2 : 33;
        lat = 0;
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        annul_i      = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk); #1;
            // Scramble operands after acceptance; the running divide must ignore them
            opdata1_i    = $urandom;
            opdata2_i    = $urandom;
            signed_div_i = 1'($urandom_range(0, 1));
            if (ready_o === 1'b1) begin
                lat = e;
                break;
            end
        end
        checks++;
        if (lat !== exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d edges, expected %0d", name, lat, exp_lat);
        end
        checks++;
        if (result_o !== exp_res) begin
            errors++;
            $display("FAIL %s result: got %h, expected %h", name, result_o, exp_res);
        end
        // One more cycle with start held: result stays presented
        @(posedge clk); #1;
        checks++;
        if (ready_o !== 1'b1 || result_o !== exp_res) begin
            errors++;
            $display("FAIL %s hold: ready=%b result=%h, expected ready=1 result=%h",
                     name, ready_o, result_o, exp_res);
        end
        if (mode == 1) begin
            annul_i = 1'b1;
        end else begin
            start_i = 1'b0;
        end
        @(posedge clk); #1;
        start_i = 1'b0;
        annul_i = 1'b0;
        checks++;
        if (ready_o !== 1'b0 || result_o !== exp_res) begin
            errors++;
            $display("FAIL %s release: ready=%b result=%h, expected ready=0 result=%h",
                     name, ready_o, result_o, exp_res);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i = 32'd0;
        opdata2_i = 32'd0;
        start_i = 1'b1;
        annul_i = 1'b0;
        #2;
        @(posedge clk); #1;
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            errors++;
            $display("FAIL reset: ready=%b result=%h, expected ready=0 result=0", ready_o, result_o);
        end
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        run_div(1'b0, 32'd100, 32'd7, 0, "udiv_100_7");
        run_div(1'b1, 32'hFFFFFFF9, 32'd2, 0, "sdiv_m7_2");
        run_div(1'b0, 32'hFFFFFFF9, 32'd2, 0, "udiv_fff9_2");
        run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 0, "sdiv_overflow");
        run_div(1'b1, 32'd7, 32'hFFFFFFFE, 0, "sdiv_7_m2");
    endtask

    task automatic test_byzero();
        run_div(1'b0, 32'h12345678, 32'd0, 0, "byzero_u");
        run_div(1'b1, 32'h87654321, 32'd0, 1, "byzero_s_annul_done");
    endtask

    task automatic test_annul_busy();
        logic [63:0] prior;
        int          saw_ready;
        prior = result_o;
        saw_ready = 0;
        signed_div_i = 1'b0;
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        start_i = 1'b1;
        annul_i = 1'b0;
        // Accepting edge plus nine BUSY edges
        for (int e = 0; e < 10; e++) begin
            @(posedge clk); #1;
        end
        annul_i = 1'b1;
        start_i = 1'b0;
        @(posedge clk); #1;
        annul_i = 1'b0;
        for (int e = 0; e < 40; e++) begin
            if (ready_o !== 1'b0) saw_ready = 1;
            @(posedge clk); #1;
        end
        checks++;
        if (saw_ready != 0 || result_o !== prior) begin
            errors++;
            $display("FAIL annul_busy: saw_ready=%0d result=%h, expected saw_ready=0 result=%h",
                     saw_ready, result_o, prior);
        end
        run_div(1'b0, 32'd9, 32'd3, 0, "after_annul_9_3");
    endtask

    task automatic test_rst_mid_busy();
        signed_div_i = 1'b0;
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        start_i = 1'b1;
        annul_i = 1'b0;
        for (int e = 0; e < 15; e++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            errors++;
            $display("FAIL rst_mid_busy: ready=%b result=%h, expected ready=0 result=0",
                     ready_o, result_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        run_div(1'b0, 32'hFFFFFFFF, 32'h10, 0, "after_rst_ffff_10");
    endtask

    task automatic test_back_to_back();
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 24; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = ~32'($urandom_range(0, 15));
                default: b = $urandom;
            endcase
            run_div(s, a, b, i % 2, "random");
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_directed();
        test_byzero();
        test_annul_busy();
        test_rst_mid_busy();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
